// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the iterative divider in execute.
//   DIV_WIDTH   : default operand width
//   DIV_LATENCY : cycles from request to the result strobe (stall cycles)
//   divState_t  : controller state encoding
package div_ctrl_pkg;

  localparam int DIV_WIDTH   = 32;
  localparam int DIV_LATENCY = DIV_WIDTH + 1;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } divState_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration.
//   remIn   : partial remainder before this step (always below the divisor)
//   divisor : unsigned divisor magnitude
//   nextBit : next dividend bit, shifted into the remainder LSB
//   remOut  : partial remainder after the conditional subtract
//   qBit    : quotient bit (1 when the subtract did not borrow)
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] remIn,
  input  logic [WIDTH-1:0] divisor,
  input  logic             nextBit,
  output logic [WIDTH-1:0] remOut,
  output logic             qBit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           borrow;

  // The shifted remainder needs WIDTH+1 bits, but whichever value is kept
  // is always below the divisor, so the result fits back into WIDTH bits.
  // With a zero divisor nothing is ever subtracted and the remainder simply
  // accumulates dividend bits, which still never exceeds WIDTH bits.
  always_comb begin
    shifted = {remIn, nextBit};
    diff    = shifted - {1'b0, divisor};
    borrow  = diff[WIDTH];
    qBit    = ~borrow;
    remOut  = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  end

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle DIV/DIVU unit for the execute stage.
//   clk, rst          : clock, synchronous active-high reset
//   startE, signedE   : divide request held while stalled; signed select
//   opaE, opbE        : dividend, divisor
//   annul             : exception flush, abandons any operation
//   div_stallE        : stall request to the hazard unit
//   hi_out, lo_out    : remainder, quotient (held until the next result)
//   res_valid         : one-cycle HI/LO write strobe
//
// state    | meaning
// ---------+---------------------------------------------------------
// DIV_IDLE | waiting for startE; operands latched on accept
// DIV_BUSY | one restoring step per cycle, ITER cycles
// DIV_DONE | results registered, res_valid high, stall released
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int ITER  = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             startE,
  input  logic             signedE,
  input  logic [WIDTH-1:0] opaE,
  input  logic [WIDTH-1:0] opbE,
  input  logic             annul,
  output logic             div_stallE,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             res_valid
);

  localparam int CntW = (ITER > 1) ? $clog2(ITER) : 1;

  divState_t        state, stateNext;
  logic [CntW-1:0]  count;
  logic [WIDTH-1:0] dvdQuo;   // dividend shifts out the top, quotient fills the bottom
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] remQ;
  logic             qSign, rSign;

  logic [WIDTH-1:0] magA, magB;
  logic [WIDTH-1:0] stepRem;
  logic             stepQ;
  logic             lastStep;
  logic [WIDTH-1:0] quoFinal;

  div_step #(.WIDTH(WIDTH)) uStep (
    .remIn  (remQ),
    .divisor(divisor),
    .nextBit(dvdQuo[WIDTH-1]),
    .remOut (stepRem),
    .qBit   (stepQ)
  );

  always_comb begin
    magA     = (signedE && opaE[WIDTH-1]) ? -opaE : opaE;
    magB     = (signedE && opbE[WIDTH-1]) ? -opbE : opbE;
    lastStep = (count == CntW'(ITER - 1));
    quoFinal = {dvdQuo[WIDTH-2:0], stepQ};
  end

  always_comb begin
    stateNext  = state;
    div_stallE = 1'b0;
    res_valid  = 1'b0;
    case (state)
      DIV_IDLE: if (startE) stateNext = DIV_BUSY;
      DIV_BUSY: if (lastStep) stateNext = DIV_DONE;
      DIV_DONE: stateNext = DIV_IDLE;
      default:  stateNext = DIV_IDLE;
    endcase
    if (annul) stateNext = DIV_IDLE;
    div_stallE = ~annul & (((state == DIV_IDLE) & startE) | (state == DIV_BUSY));
    res_valid  = ~annul & (state == DIV_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= DIV_IDLE;
      count   <= '0;
      dvdQuo  <= '0;
      divisor <= '0;
      remQ    <= '0;
      qSign   <= 1'b0;
      rSign   <= 1'b0;
      hi_out  <= '0;
      lo_out  <= '0;
    end else begin
      state <= stateNext;
      case (state)
        DIV_IDLE: begin
          if (startE && !annul) begin
            dvdQuo  <= magA;
            divisor <= magB;
            qSign   <= signedE & (opaE[WIDTH-1] ^ opbE[WIDTH-1]);
            rSign   <= signedE & opaE[WIDTH-1];
            remQ    <= '0;
            count   <= '0;
          end
        end
        DIV_BUSY: begin
          if (!annul) begin
            remQ   <= stepRem;
            dvdQuo <= quoFinal;
            count  <= count + CntW'(1);
            // Results land on entry to DONE so they are fresh while res_valid is high.
            if (lastStep) begin
              lo_out <= qSign ? -quoFinal : quoFinal;
              hi_out <= rSign ? -stepRem : stepRem;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
